// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: FSM state encodings and forwarding-select codes shared by the hazard controller.
package hazard_ctrl_pkg;
    typedef enum logic {ST_RUN = 1'b0, ST_MEM_WAIT = 1'b1} state_t;
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    // The MEM-stage result is younger than WB, so it wins when both match.
    function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
        return mem_hit ? FWD_MEM : wb_hit ? FWD_WB : FWD_RF;
    endfunction
endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    always_ff @(posedge clk)
        if (rst) cnt <= '0;
        else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: 5-stage pipeline forwarding, load-use bubbles, branch flushes and data-memory freezes.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int RA_W        = 5,
    parameter int FLUSH_DEPTH = 3,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RA_W-1:0]  id_rs1,
    input  logic [RA_W-1:0]  id_rs2,
    input  logic [RA_W-1:0]  ex_rs1,
    input  logic [RA_W-1:0]  ex_rs2,
    input  logic [RA_W-1:0]  ex_rd,
    input  logic             ex_mem_read,
    input  logic [RA_W-1:0]  mem_rd,
    input  logic             mem_reg_write,
    input  logic [RA_W-1:0]  wb_rd,
    input  logic             wb_reg_write,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int WC_W = MEM_TIMEOUT < 2 ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WC_W-1:0] TO = WC_W'(MEM_TIMEOUT);
    state_t state_q, state_d;
    logic [WC_W-1:0] wait_cnt, wc_d;
    logic pending_br, pb_d, load_use, timeout, freeze, br_flush, hz_flush;
    assign fwd_a = fwd_sel(mem_reg_write && ex_rs1 != '0 && mem_rd == ex_rs1,
                           wb_reg_write && ex_rs1 != '0 && wb_rd == ex_rs1);
    assign fwd_b = fwd_sel(mem_reg_write && ex_rs2 != '0 && mem_rd == ex_rs2,
                           wb_reg_write && ex_rs2 != '0 && wb_rd == ex_rs2);
    assign load_use = ex_mem_read && ex_rd != '0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
    assign timeout = MEM_TIMEOUT != 0 && wait_cnt == TO;
    always_comb begin
        state_d = state_q;
        wc_d = wait_cnt;
        pb_d = pending_br;
        freeze = 1'b0;
        br_flush = 1'b0;
        mem_err = 1'b0;
        pc_en = 1'b1;
        if_id_en = 1'b1;
        id_ex_en = 1'b1;
        ex_mem_en = 1'b1;
        mem_wb_en = 1'b1;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        hz_flush = 1'b0;
        if (state_q == ST_RUN) begin
            if (mem_req && !mem_ready) begin
                freeze = 1'b1;
                state_d = ST_MEM_WAIT;
                wc_d = WC_W'(1);
                pb_d = branch_taken;
            end else if (branch_taken) begin
                br_flush = 1'b1;
            end else if (load_use) begin
                pc_en = 1'b0;
                if_id_en = 1'b0;
                id_ex_flush = 1'b1;
                hz_flush = 1'b1;
            end
        end else if (mem_ready) begin
            state_d = ST_RUN;
            br_flush = pending_br;
            pb_d = 1'b0;
        end else if (timeout) begin
            state_d = ST_RUN;
            mem_err = 1'b1;
            ex_mem_flush = 1'b1;
            pb_d = 1'b0;
        end else begin
            freeze = 1'b1;
            wc_d = wait_cnt + 1'b1;
        end
        if (freeze) begin
            pc_en = 1'b0;
            if_id_en = 1'b0;
            id_ex_en = 1'b0;
            ex_mem_en = 1'b0;
            mem_wb_en = 1'b0;
            mem_wb_flush = 1'b1;
        end
        // Youngest stages are flushed first; depth decides how far back the squash reaches.
        if (br_flush) begin
            if_id_flush = 1'b1;
            id_ex_flush = id_ex_flush || FLUSH_DEPTH >= 2;
            ex_mem_flush = ex_mem_flush || FLUSH_DEPTH >= 3;
            hz_flush = 1'b1;
        end
    end
    always_ff @(posedge clk)
        if (rst) begin
            state_q <= ST_RUN;
            wait_cnt <= '0;
            pending_br <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_cnt <= wc_d;
            pending_br <= pb_d;
        end
    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (.clk(clk), .rst(rst), .inc(!pc_en), .cnt(stall_cnt));
    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (.clk(clk), .rst(rst), .inc(hz_flush), .cnt(flush_cnt));
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed stimulus with a per-cycle reference model and literal spot checks.
module tb_hazard_ctrl;
    localparam int RA_W = 5, FD = 3, TMO = 16, CNT_W = 4, CMAX = 15;
    logic clk = 0, rst;
    logic [RA_W-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic ex_mem_read, mem_reg_write, wb_reg_write, branch_taken, mem_req, mem_ready;
    logic [1:0] fwd_a, fwd_b;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, mem_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    int total = 0, bad = 0;
    bit chk_on = 0;
    bit m_wait = 0, m_pend = 0;
    int m_waits = 0, m_stall = 0, m_flush = 0;

    hazard_ctrl #(.RA_W(RA_W), .FLUSH_DEPTH(FD), .MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .branch_taken(branch_taken), .mem_req(mem_req),
        .mem_ready(mem_ready), .fwd_a(fwd_a), .fwd_b(fwd_b), .pc_en(pc_en), .if_id_en(if_id_en),
        .id_ex_en(id_ex_en), .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_fwd(input logic [RA_W-1:0] src);
        if (src == 0) return 2'b00;
        if (mem_reg_write && mem_rd == src) return 2'b10;
        if (wb_reg_write && wb_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    // Reference model: decides each cycle's action from the rules, then advances its own state.
    always @(negedge clk) if (chk_on) begin : cmp
        bit frz, brf, lu, e_lu, e_err, e_front;
        lu = ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
        frz = 0; brf = 0; e_lu = 0; e_err = 0;
        if (!m_wait) begin
            if (mem_req && !mem_ready) frz = 1;
            else if (branch_taken) brf = 1;
            else if (lu) e_lu = 1;
        end else if (mem_ready) brf = m_pend;
        else if (m_waits == TMO) e_err = 1;
        else frz = 1;
        e_front = !(frz || e_lu);
        chk("enables", {pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en},
            {e_front, e_front, !frz, !frz, !frz});
        chk("flushes", {if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush},
            {brf, (brf && FD >= 2) || e_lu, (brf && FD >= 3) || e_err, frz});
        chk("mem_err", mem_err, e_err);
        chk("fwd_a", fwd_a, exp_fwd(ex_rs1));
        chk("fwd_b", fwd_b, exp_fwd(ex_rs2));
        chk("stall_cnt", stall_cnt, m_stall);
        chk("flush_cnt", flush_cnt, m_flush);
        if (rst) begin
            m_wait = 0; m_pend = 0; m_waits = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (!e_front) m_stall = m_stall < CMAX ? m_stall + 1 : CMAX;
            if (brf || e_lu) m_flush = m_flush < CMAX ? m_flush + 1 : CMAX;
            if (!m_wait && frz) begin
                m_wait = 1; m_waits = 1; m_pend = branch_taken;
            end else if (m_wait) begin
                if (mem_ready || e_err) begin m_wait = 0; m_pend = 0; end
                else m_waits++;
            end
        end
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
        {ex_mem_read, mem_reg_write, wb_reg_write, branch_taken, mem_req, mem_ready} = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1; idle();
        cyc(); chk_on = 1;
        cyc(); rst = 0;
        @(negedge clk); chk("rst_pc_en", pc_en, 1); chk("rst_stall", stall_cnt, 0);
        cyc(); mem_rd = 5; mem_reg_write = 1; wb_rd = 5; wb_reg_write = 1; ex_rs1 = 5;
        @(negedge clk); chk("fwd_mem", fwd_a, 2'b10);
        cyc(); ex_rs1 = 0;
        @(negedge clk); chk("fwd_x0", fwd_a, 2'b00);
        cyc(); ex_rs1 = 5; ex_rs2 = 5; mem_reg_write = 0;
        @(negedge clk); chk("fwd_wb_a", fwd_a, 2'b01); chk("fwd_wb_b", fwd_b, 2'b01);
        cyc(); idle(); ex_mem_read = 1; ex_rd = 7; id_rs2 = 7;
        @(negedge clk); chk("lu_front", {pc_en, if_id_en, id_ex_flush}, 3'b001);
        cyc(); idle();
        @(negedge clk); chk("lu_cnts", {flush_cnt, stall_cnt}, {4'd1, 4'd1}); chk("lu_clear", pc_en, 1);
        cyc(); ex_mem_read = 1; ex_rd = 7; id_rs1 = 7; branch_taken = 1;
        @(negedge clk); chk("br_flush", {if_id_flush, id_ex_flush, ex_mem_flush, pc_en}, 4'b1111);
        cyc(); idle(); mem_req = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); chk("wait_frozen", {pc_en, mem_wb_en, mem_wb_flush}, 3'b001);
            cyc();
        end
        mem_ready = 1;
        @(negedge clk); chk("wait_resume", {pc_en, mem_wb_en, mem_wb_flush}, 3'b110);
        cyc(); idle();
        @(negedge clk); chk("wait_stall", stall_cnt, 5); chk("wait_flush", flush_cnt, 2);
        cyc(); mem_req = 1; branch_taken = 1;
        cyc(); mem_req = 0;
        cyc(); branch_taken = 0; mem_ready = 1;
        @(negedge clk); chk("pend_br", {if_id_flush, ex_mem_flush, pc_en}, 3'b111);
        cyc(); idle(); mem_req = 1; mem_ready = 1;
        @(negedge clk); chk("zero_lat", {pc_en, mem_wb_flush}, 2'b10);
        cyc(); idle(); mem_req = 1;
        cyc(); mem_req = 0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (mem_err) begin n = i; break; end
            cyc();
        end
        chk("tmo_cycle", n, 16); chk("tmo_flush", {ex_mem_flush, pc_en}, 2'b11);
        cyc();
        @(negedge clk); chk("tmo_sat", stall_cnt, 15); chk("tmo_run", {pc_en, mem_err}, 2'b10);
        cyc(); mem_req = 1;
        cyc(); mem_req = 0;
        repeat (15) cyc();
        mem_ready = 1;
        @(negedge clk); chk("ready_wins", {mem_err, pc_en}, 2'b01);
        cyc(); idle(); mem_req = 1;
        cyc(); mem_req = 0;
        cyc(); cyc(); rst = 1;
        cyc(); rst = 0;
        @(negedge clk);
        chk("rst_wait", {pc_en, mem_wb_flush, mem_err, stall_cnt, flush_cnt}, {3'b100, 8'd0});
        cyc(); ex_mem_read = 1; ex_rd = 3; id_rs1 = 3;
        repeat (20) cyc();
        idle();
        @(negedge clk); chk("sat_stall", stall_cnt, 15); chk("sat_flush", flush_cnt, 15);
        cyc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
